// File: rtl/uart_recv.sv
// UART 8N1 receiver: 2-FF synchronized line, mid-bit sampling, one-cycle valid/frame_err pulses.
// Optional macro RX_MAJORITY_EN: each sample is the majority of the last three synchronized values.
module uart_recv #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_n;
    logic valid_n, frame_err_n;
    logic sync1, rx_s;
    logic samp;

    // Synchronizer flops reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= din;
            rx_s  <= sync1;
        end
    end

`ifdef RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rx_s};
    end

    assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign samp = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        shreg_n     = shreg;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = samp ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {samp, shreg[7:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (samp) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BRK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BRK: begin
                // A line held low after a bad stop bit must not look like a new start bit.
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv with CLKS_PER_BIT=16; expected bytes are hand-computed per frame.
module tb_uart_recv;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst;
   logic din;
   logic [7:0] data;
   logic valid;
   logic frameErr;

   int checks = 0;
   int errors = 0;
   int validCount = 0;
   int errCount = 0;
   logic bothHigh = 1'b0;
   logic longPulse = 1'b0;
   logic prevValid = 1'b0;
   logic prevErr = 1'b0;
   logic [7:0] dataLog[$];

   uart_recv #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .data(data),
      .valid(valid),
      .frame_err(frameErr)
   );

   always #5 clk = ~clk;

   // Pulse monitor sampling on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (valid) begin
         validCount++;
         dataLog.push_back(data);
      end
      if (frameErr) errCount++;
      if (valid && frameErr) bothHigh = 1'b1;
      if ((valid && prevValid) || (frameErr && prevErr)) longPulse = 1'b1;
      prevValid = valid;
      prevErr = frameErr;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      din = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 8N1 frame, one line level per clock; spikeCycle forces din low for that cycle,
   // and nCycles can cut the frame short.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int spikeCycle, input int nCycles);
      int bitIdx;
      logic level;
      for (int c = 0; c < nCycles; c++) begin
         bitIdx = c / CPB;
         if (bitIdx == 0) level = 1'b0;
         else if (bitIdx <= 8) level = b[bitIdx-1];
         else level = stopBit;
         if (c == spikeCycle) level = 1'b0;
         din = level;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int v0;
      int e0;
      int q0;
      logic [7:0] hitsz[5];
      logic [7:0] spikeExp;
      hitsz[0] = 8'h68; hitsz[1] = 8'h69; hitsz[2] = 8'h74; hitsz[3] = 8'h73; hitsz[4] = 8'h7A;

      // Reset values and a long idle line.
      rst = 1'b1;
      din = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstData", data, 8'h00);
      checkOutput("rstValid", valid, 1'b0);
      checkOutput("rstFrameErr", frameErr, 1'b0);
      rst = 1'b0;
      idleCycles(500);
      checkOutput("idleValid", validCount, 0);
      checkOutput("idleFrameErr", errCount, 0);
      checkOutput("idleData", data, 8'h00);

      // Single byte 'h'.
      applyStimulus(8'h68, 1'b1, -1, 10 * CPB);
      idleCycles(20);
      checkOutput("hValid", validCount, 1);
      checkOutput("hFrameErr", errCount, 0);
      checkOutput("hData", data, 8'h68);

      // Back-to-back "hitsz".
      v0 = validCount;
      q0 = dataLog.size();
      for (int i = 0; i < 5; i++) applyStimulus(hitsz[i], 1'b1, -1, 10 * CPB);
      idleCycles(20);
      checkOutput("hitszCount", validCount - v0, 5);
      for (int i = 0; i < 5; i++) begin
         if (q0 + i < dataLog.size()) checkOutput($sformatf("hitsz%0d", i), dataLog[q0+i], hitsz[i]);
         else checkOutput($sformatf("hitsz%0dMissing", i), 0, 1);
      end
      checkOutput("hitszFrameErr", errCount, 0);

      // Three-cycle glitch, then '2'.
      v0 = validCount;
      din = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      idleCycles(20);
      checkOutput("glitchValid", validCount - v0, 0);
      applyStimulus(8'h32, 1'b1, -1, 10 * CPB);
      idleCycles(20);
      checkOutput("afterGlitchValid", validCount - v0, 1);
      checkOutput("afterGlitchData", data, 8'h32);

      // Bad stop bit, line held low, then '1'.
      v0 = validCount;
      e0 = errCount;
      applyStimulus(8'h55, 1'b0, -1, 10 * CPB);
      din = 1'b0;
      repeat (3 * CPB) begin
         @(posedge clk);
         #1;
      end
      idleCycles(20);
      checkOutput("breakFrameErr", errCount - e0, 1);
      checkOutput("breakValid", validCount - v0, 0);
      checkOutput("breakData", data, 8'h32);
      applyStimulus(8'h31, 1'b1, -1, 10 * CPB);
      idleCycles(20);
      checkOutput("afterBreakValid", validCount - v0, 1);
      checkOutput("afterBreakData", data, 8'h31);
      checkOutput("afterBreakFrameErr", errCount - e0, 1);

      // Reset in the middle of bit 4 of 0xA5.
      v0 = validCount;
      e0 = errCount;
      applyStimulus(8'hA5, 1'b1, -1, 5 * CPB + CPB / 2);
      rst = 1'b1;
      #1;
      checkOutput("midRstData", data, 8'h00);
      checkOutput("midRstValid", valid, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idleCycles(20);
      checkOutput("midRstNoPulse", validCount - v0, 0);
      checkOutput("midRstNoErr", errCount - e0, 0);
      applyStimulus(8'h38, 1'b1, -1, 10 * CPB);
      idleCycles(20);
      checkOutput("afterRstValid", validCount - v0, 1);
      checkOutput("afterRstData", data, 8'h38);

      // One-cycle low spike at the centre of bit 0 of 0xFF.
`ifdef RX_MAJORITY_EN
      spikeExp = 8'hFF;
`else
      spikeExp = 8'hFE;
`endif
      v0 = validCount;
      applyStimulus(8'hFF, 1'b1, CPB + CPB / 2, 10 * CPB);
      idleCycles(20);
      checkOutput("spikeValid", validCount - v0, 1);
      checkOutput("spikeData", data, spikeExp);

      checkOutput("neverBothHigh", bothHigh, 1'b0);
      checkOutput("singleCyclePulses", longPulse, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
